// File: rtl/weight_read_sched_pkg.sv
// weight_read_sched_pkg: shared widths, read latency and FSM encodings for the weight read scheduler
package weight_read_sched_pkg;
  localparam int ADDR_SIZE_DEF = 10;
  localparam int DATA_WIDTH = 16;
  localparam int DIM_W_DEF = 8;
  localparam int RAM_RD_LAT = 1;
  typedef enum logic [2:0] {IDLE, WAIT_LOAD, ISSUE, DRAIN, DONE} state_t;
endpackage

// File: rtl/weight_addr_gen.sv
// weight_addr_gen: k/oc/pass counters and row_base accumulator producing weight RAM addresses
//   load            : capture base/k_len/n_oc/n_pass and clear the counters
//   step            : advance one word (k, then oc, then pass)
//   addr            : row_base + k, modulo 2^ADDR_SIZE
//   first/row_last  : current word is k=0 / k=k_len-1 of its row
//   last            : current word is the final word of the final pass
module weight_addr_gen
  import weight_read_sched_pkg::*;
#(
  parameter int ADDR_SIZE = ADDR_SIZE_DEF,
  parameter int DIM_W = DIM_W_DEF
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 load,
  input  logic                 step,
  input  logic [ADDR_SIZE-1:0] base,
  input  logic [DIM_W-1:0]     k_len,
  input  logic [DIM_W-1:0]     n_oc,
  input  logic [DIM_W-1:0]     n_pass,
  output logic [ADDR_SIZE-1:0] addr,
  output logic                 first,
  output logic                 row_last,
  output logic                 last
);
  logic [ADDR_SIZE-1:0] base_q, row_base;
  logic [DIM_W-1:0] k_len_q, n_oc_q, n_pass_q, k, oc, pass;
  logic oc_last;
  always_comb begin
    addr = row_base + ADDR_SIZE'(k);
    first = k == '0;
    row_last = k == k_len_q - 1'b1;
    oc_last = oc == n_oc_q - 1'b1;
    last = row_last && oc_last && pass == n_pass_q - 1'b1;
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      base_q <= '0;
      row_base <= '0;
      k_len_q <= '0;
      n_oc_q <= '0;
      n_pass_q <= '0;
      k <= '0;
      oc <= '0;
      pass <= '0;
    end else if (load) begin
      base_q <= base;
      row_base <= base;
      k_len_q <= k_len;
      n_oc_q <= n_oc;
      n_pass_q <= n_pass;
      k <= '0;
      oc <= '0;
      pass <= '0;
    end else if (step) begin
      k <= row_last ? '0 : k + 1'b1;
      oc <= !row_last ? oc : oc_last ? '0 : oc + 1'b1;
      pass <= row_last && oc_last ? pass + 1'b1 : pass;
      row_base <= !row_last ? row_base : oc_last ? base_q : row_base + ADDR_SIZE'(k_len_q);
    end
  end
endmodule

// File: rtl/weight_read_sched.sv
// weight_read_sched: streams weight RAM read addresses once a DMA load completes, with row markers
//   conv_en/abort/w_last : start, cancel, DMA final-beat (sets the loaded flag)
//   cfg_*                : base address and k_len/n_oc/n_pass, sampled on an accepted start
//   pe_ready             : downstream accepts a word two cycles later
//   weight_addr/w_addr_vld : RAM read port
//   wdat_vld/row_first/row_last : read data qualifiers, one cycle behind the address
//   w_done/busy/cfg_err  : completion pulse, activity, zero-size config rejection pulse
module weight_read_sched
  import weight_read_sched_pkg::*;
#(
  parameter int ADDR_SIZE = ADDR_SIZE_DEF,
  parameter int DIM_W = DIM_W_DEF
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 conv_en,
  input  logic                 abort,
  input  logic                 w_last,
  input  logic [ADDR_SIZE-1:0] cfg_base,
  input  logic [DIM_W-1:0]     cfg_k_len,
  input  logic [DIM_W-1:0]     cfg_n_oc,
  input  logic [DIM_W-1:0]     cfg_n_pass,
  input  logic                 pe_ready,
  output logic [ADDR_SIZE-1:0] weight_addr,
  output logic                 w_addr_vld,
  output logic                 wdat_vld,
  output logic                 row_first,
  output logic                 row_last,
  output logic                 w_done,
  output logic                 busy,
  output logic                 cfg_err
);
  state_t state;
  logic loaded, a_first, a_last, cfg_zero, start, bad_start, step, done_now;
  logic gen_first, gen_row_last, gen_last;
  logic [ADDR_SIZE-1:0] gen_addr;
  always_comb begin
    cfg_zero = cfg_k_len == '0 || cfg_n_oc == '0 || cfg_n_pass == '0;
    start = state == IDLE && conv_en && !cfg_zero;
    bad_start = state == IDLE && conv_en && cfg_zero;
    step = state == ISSUE && pe_ready && !abort;
    done_now = (state == DONE && !abort) || bad_start;
    busy = state != IDLE;
  end
  weight_addr_gen #(.ADDR_SIZE(ADDR_SIZE), .DIM_W(DIM_W)) u_gen (
    .clk(clk),
    .rstn(rstn),
    .load(start),
    .step(step),
    .base(cfg_base),
    .k_len(cfg_k_len),
    .n_oc(cfg_n_oc),
    .n_pass(cfg_n_pass),
    .addr(gen_addr),
    .first(gen_first),
    .row_last(gen_row_last),
    .last(gen_last)
  );
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      loaded <= 1'b0;
      weight_addr <= '0;
      w_addr_vld <= 1'b0;
      a_first <= 1'b0;
      a_last <= 1'b0;
      wdat_vld <= 1'b0;
      row_first <= 1'b0;
      row_last <= 1'b0;
      w_done <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      // a new DMA beat wins over the clear from a completing run
      loaded <= w_last || (loaded && !done_now);
      wdat_vld <= w_addr_vld;
      row_first <= w_addr_vld && a_first;
      row_last <= w_addr_vld && a_last;
      w_addr_vld <= step;
      w_done <= done_now;
      cfg_err <= bad_start;
      if (step) begin
        weight_addr <= gen_addr;
        a_first <= gen_first;
        a_last <= gen_row_last;
      end
      if (abort && state != IDLE) state <= IDLE;
      else
        case (state)
          IDLE: if (start) state <= WAIT_LOAD;
          WAIT_LOAD: if (loaded) state <= ISSUE;
          ISSUE: if (step && gen_last) state <= DRAIN;
          DRAIN: state <= DONE;
          DONE: state <= IDLE;
          default: state <= IDLE;
        endcase
    end
  end
endmodule

// File: tb/tb_weight_read_sched.sv
// tb_weight_read_sched: directed self-checking bench for weight_read_sched
module tb_weight_read_sched;
  localparam int AW = 10;
  localparam int DW = 8;
  logic clk = 1'b0, rstn = 1'b0, conv_en = 1'b0, abort = 1'b0, w_last = 1'b0, pe_ready = 1'b1;
  logic [AW-1:0] cfg_base = '0;
  logic [DW-1:0] cfg_k_len = '0, cfg_n_oc = '0, cfg_n_pass = '0;
  logic [AW-1:0] weight_addr;
  logic w_addr_vld, wdat_vld, row_first, row_last, w_done, busy, cfg_err;
  int checks = 0, errors = 0;
  logic [AW-1:0] addrs[$];
  int acyc[$];
  int nb, done_cyc, viol, cnt;
  logic [15:0] fmask, lmask;
  always #5 clk = ~clk;
  weight_read_sched dut (
    .clk(clk), .rstn(rstn), .conv_en(conv_en), .abort(abort), .w_last(w_last),
    .cfg_base(cfg_base), .cfg_k_len(cfg_k_len), .cfg_n_oc(cfg_n_oc), .cfg_n_pass(cfg_n_pass),
    .pe_ready(pe_ready), .weight_addr(weight_addr), .w_addr_vld(w_addr_vld), .wdat_vld(wdat_vld),
    .row_first(row_first), .row_last(row_last), .w_done(w_done), .busy(busy), .cfg_err(cfg_err)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic load_w();
    w_last = 1'b1;
    step();
    w_last = 1'b0;
  endtask
  task automatic start(input logic [AW-1:0] b, input int kl, input int no, input int np);
    cfg_base = b;
    cfg_k_len = DW'(kl);
    cfg_n_oc = DW'(no);
    cfg_n_pass = DW'(np);
    conv_en = 1'b1;
    step();
    conv_en = 1'b0;
    cfg_base = '1;
    cfg_k_len = 8'd7;
    cfg_n_oc = 8'd5;
    cfg_n_pass = 8'd9;
  endtask
  task automatic run(input int maxc, input bit alt);
    addrs.delete();
    acyc.delete();
    nb = 0;
    fmask = '0;
    lmask = '0;
    done_cyc = -1;
    viol = 0;
    for (int c = 0; c < maxc && done_cyc < 0; c++) begin
      pe_ready = alt ? c[0] : 1'b1;
      step();
      if (w_addr_vld) begin
        addrs.push_back(weight_addr);
        acyc.push_back(c);
        if (!pe_ready) viol++;
      end
      if (wdat_vld) begin
        if (nb < 16) begin
          fmask[nb] = row_first;
          lmask[nb] = row_last;
        end
        nb++;
      end
      if (w_done) done_cyc = c;
    end
    pe_ready = 1'b1;
  endtask
  task automatic check_seq(input string tag, input logic [AW-1:0] b, input int kl, input int no, input int np);
    int i;
    logic [AW-1:0] ea;
    logic [15:0] ef, el;
    i = 0;
    ef = '0;
    el = '0;
    chk({tag, "_done_seen"}, done_cyc >= 0, 1);
    chk({tag, "_naddr"}, addrs.size(), kl * no * np);
    chk({tag, "_nbeats"}, nb, kl * no * np);
    for (int p = 0; p < np; p++)
      for (int o = 0; o < no; o++)
        for (int k = 0; k < kl; k++) begin
          ea = b + AW'(o * kl + k);
          if (i < addrs.size()) chk({tag, "_addr"}, addrs[i], ea);
          ef[i] = k == 0;
          el[i] = k == kl - 1;
          i++;
        end
    chk({tag, "_first_mask"}, fmask, ef);
    chk({tag, "_last_mask"}, lmask, el);
  endtask
  initial begin
    #1;
    chk("rst_outs", {weight_addr, w_addr_vld, wdat_vld, row_first, row_last, w_done, busy, cfg_err}, 0);
    step();
    step();
    rstn = 1'b1;
    step();
    // basic run with weights already loaded
    load_w();
    start(10'h010, 3, 2, 1);
    chk("basic_busy", busy, 1);
    run(60, 1'b0);
    check_seq("basic", 10'h010, 3, 2, 1);
    if (acyc.size() == 6) begin
      chk("basic_latency", acyc[0], 1);
      chk("basic_contig", acyc[5] - acyc[0], 5);
      chk("basic_done_gap", done_cyc - acyc[5], 2);
    end
    chk("basic_idle", busy, 0);
    step();
    chk("basic_done_1cyc", w_done, 0);
    // loaded was cleared by w_done, so this start must wait for w_last
    start(10'h010, 3, 2, 1);
    cnt = 0;
    repeat (5) begin
      step();
      cnt += int'(w_addr_vld);
    end
    chk("wait_no_vld", cnt, 0);
    chk("wait_busy", busy, 1);
    load_w();
    run(60, 1'b0);
    check_seq("late_load", 10'h010, 3, 2, 1);
    if (acyc.size() > 0) chk("late_latency", acyc[0], 1);
    // backpressure over three passes
    load_w();
    start(10'h100, 2, 1, 3);
    run(100, 1'b1);
    check_seq("bp", 10'h100, 2, 1, 3);
    chk("bp_stall_viol", viol, 0);
    // address wrap-around
    load_w();
    start(10'h3FE, 4, 1, 1);
    run(60, 1'b0);
    check_seq("wrap", 10'h3FE, 4, 1, 1);
    // zero-size config
    load_w();
    start(10'h010, 3, 0, 1);
    chk("zero_cfg_err", cfg_err, 1);
    chk("zero_w_done", w_done, 1);
    chk("zero_busy", busy, 0);
    run(8, 1'b0);
    chk("zero_no_addr", addrs.size(), 0);
    chk("zero_no_more_done", done_cyc, 32'hFFFF_FFFF);
    chk("zero_err_cleared", cfg_err, 0);
    // abort at the third beat
    load_w();
    start(10'h020, 3, 2, 1);
    cnt = 0;
    for (int c = 0; c < 20 && cnt < 3; c++) begin
      step();
      cnt += int'(w_addr_vld);
    end
    chk("abort_pre_beats", cnt, 3);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_vld", w_addr_vld, 0);
    chk("abort_inflight", wdat_vld, 1);
    step();
    chk("abort_inflight_once", wdat_vld, 0);
    cnt = 0;
    repeat (5) begin
      step();
      cnt += int'(w_done);
    end
    chk("abort_no_done", cnt, 0);
    start(10'h020, 3, 2, 1);
    run(60, 1'b0);
    check_seq("restart", 10'h020, 3, 2, 1);
    // asynchronous reset mid-issue
    load_w();
    start(10'h040, 4, 2, 1);
    cnt = 0;
    for (int c = 0; c < 20 && cnt < 2; c++) begin
      step();
      cnt += int'(w_addr_vld);
    end
    chk("midrst_pre_vld", w_addr_vld, 1);
    #2;
    rstn = 1'b0;
    #1;
    chk("midrst_outs", {weight_addr, w_addr_vld, wdat_vld, row_first, row_last, w_done, busy, cfg_err}, 0);
    step();
    chk("midrst_hold", {w_addr_vld, wdat_vld, busy}, 0);
    rstn = 1'b1;
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
